wall_row_shader: RTL and testbench
==================================

// Module: wall_row_shader
// PURPOSE
// - Pixel stage directly downstream of the VGA timing generator: consumes hpos/vpos/visible/hmax/vmax/hsync/vsync.
// - Tracer hands over one wall height per display line; block double-buffers it and paints sky | wall | floor.
// - Outputs 6-bit RGB plus hsync/vsync re-registered so colour and sync stay aligned.
// PARAMETERS
// - H_VIEW     640        visible pixels per line
// - V_VIEW     480        visible lines per frame
// - SKY_RGB    6'b01_01_11  colour for hpos < wall_start, {R,G,B} 2 bits each
// - FLOOR_RGB  6'b01_01_01  colour for hpos >= wall_end
// - WALL0_RGB  6'b11_00_00  wall colour, side=0
// - WALL1_RGB  6'b10_00_00  wall colour, side=1
// PORTS
// - clk        in   1   pixel clock, sole clock
// - reset      in   1   synchronous, active-high
// - hpos       in   10  current pixel column from timing generator
// - vpos       in   10  current line from timing generator
// - hmax       in   1   last clock of line
// - vmax       in   1   last line of frame
// - visible    in   1   hpos<H_VIEW && vpos<V_VIEW
// - hsync_in   in   1   raw hsync from timing generator
// - vsync_in   in   1   raw vsync from timing generator
// - wr_valid   in   1   tracer offers height for next visible line
// - wr_height  in   10  wall height in pixels (0 = no wall)
// - wr_side    in   1   wall side select (shading)
// - wr_ready   out  1   pending slot empty; transfer when wr_valid && wr_ready
// - rgb        out  6   {R[1:0],G[1:0],B[1:0]}
// - hsync      out  1   hsync_in delayed 1 clk
// - vsync      out  1   vsync_in delayed 1 clk
// - underrun   out  1   1-clk pulse: swap due but pending slot empty
// BEHAVIOUR
// - Reset: pend_full=0, active start=end=H_VIEW/2 (no wall), side=0; rgb=0, hsync=0, vsync=0, underrun=0; wr_ready=1 next cycle.
// - wr_ready = ~pend_full (combinational from register). Accept latches height-derived start/end and side into pending slot, sets pend_full.
// - Span math at accept: half=wr_height>>1; start = (half>=H_VIEW/2) ? 0 : H_VIEW/2-half; end = min(H_VIEW/2+half, H_VIEW). 11-bit intermediate, no wrap.
// - Swap condition: hmax && (vmax || vpos < V_VIEW-1), i.e. last clock before each visible line.
// - On swap with pend_full: active<=pending, pend_full<=0. With pend_empty: active retained, underrun=1 next clk.
// - Accept on swap cycle: only possible when pending empty (ready from pre-state); data goes to pending, not active; underrun still fires.
// - Swap never occurs in vblank lines other than the one preceding line 0; pending may be filled during vblank and is held.
// - Colour, registered (latency 1): !visible -> 0; hpos<start -> SKY; hpos<end -> WALL0/WALL1 by side; else FLOOR.
// - hsync/vsync registered same edge as rgb: sync-to-pixel alignment identical to timing generator outputs.
// - Reset mid-line: all state cleared next edge, pending discarded; no partial transfer.
// STRUCTURE
// - Shared package: H_VIEW, V_VIEW, RGB width, default colour constants (shared with timing gen and tracer).
// - Single sub-module: row_span_buffer (pending/active slots, span math, handshake, underrun); shading mux in top.
// TESTING
// - Reset then idle frame, no writes -> rgb 0 in blanking, SKY cols 0..319, FLOOR 320..639, underrun on each of 480 swaps.
// - Write height=200 side=0 before line 5 -> line 5: SKY 0..219, WALL0 220..419, FLOOR 420..639.
// - Height=1023 side=1 -> start=0, end=640; whole visible line WALL1, no out-of-range wrap.
// - Hold wr_valid after accept -> wr_ready=0 until swap; second value appears one line later, none lost.
// - Write presented exactly on swap cycle with pending empty -> underrun=1, value shown on following line.
// - Assert reset at hpos=300 with pending full -> next edge rgb=0, wr_ready=1, previous pending never displayed.

Source files
------------

// File: rtl/wall_row_shader_pkg.sv
// Shared constants and types for the wall row shader: view geometry,
// colour palette, the per-line span record and the height-to-span helper.
package wall_row_shader_pkg;

   localparam int unsigned H_VIEW = 640;
   localparam int unsigned V_VIEW = 480;
   localparam int unsigned RGB_W  = 6;
   localparam int unsigned POS_W  = 10;

   // Colours are {R[1:0], G[1:0], B[1:0]}
   localparam logic [RGB_W-1:0] SKY_RGB   = 6'b01_01_11;
   localparam logic [RGB_W-1:0] FLOOR_RGB = 6'b01_01_01;
   localparam logic [RGB_W-1:0] WALL0_RGB = 6'b11_00_00;
   localparam logic [RGB_W-1:0] WALL1_RGB = 6'b10_00_00;
   localparam logic [RGB_W-1:0] BLANK_RGB = 6'b00_00_00;

   // 11-bit helpers so span arithmetic never wraps
   localparam logic [POS_W:0]   HALF_VIEW     = 11'(H_VIEW / 2);
   localparam logic [POS_W:0]   SPAN_LIMIT    = 11'(H_VIEW);
   localparam logic [POS_W-1:0] CENTRE_COL    = 10'(H_VIEW / 2);
   localparam logic [POS_W-1:0] LAST_VIS_LINE = 10'(V_VIEW - 1);

   typedef enum logic {
      SIDE_0 = 1'b0,
      SIDE_1 = 1'b1
   } wall_side_e;

   // Horizontal wall extent for one line: wall covers start <= hpos < stop
   typedef struct packed {
      logic [POS_W-1:0] start;
      logic [POS_W-1:0] stop;
      wall_side_e       side;
   } span_t;

   // Empty span centred on the screen: everything left is sky, right is floor
   localparam span_t NO_WALL = '{start: CENTRE_COL, stop: CENTRE_COL, side: SIDE_0};

   // Wall is centred; start clamps at column 0 and stop at H_VIEW
   function automatic span_t height_to_span(input logic [POS_W-1:0] height,
                                            input logic             side);
      logic [POS_W:0] half;
      logic [POS_W:0] lo;
      logic [POS_W:0] hi;
      span_t          s;
      half = {2'b00, height[POS_W-1:1]};
      lo   = (half >= HALF_VIEW) ? '0 : (HALF_VIEW - half);
      hi   = HALF_VIEW + half;
      if (hi > SPAN_LIMIT) begin
         hi = SPAN_LIMIT;
      end
      s.start = lo[POS_W-1:0];
      s.stop  = hi[POS_W-1:0];
      s.side  = wall_side_e'(side);
      return s;
   endfunction

endpackage

// File: rtl/wall_row_shader_if.sv
// Height handoff from the ray tracer to the row shader (valid/ready).
interface wall_row_shader_if;
   import wall_row_shader_pkg::*;

   logic             wr_valid;
   logic [POS_W-1:0] wr_height;
   logic             wr_side;
   logic             wr_ready;

   // Tracer side
   modport master (
      output wr_valid,
      output wr_height,
      output wr_side,
      input  wr_ready
   );

   // Shader side
   modport slave (
      input  wr_valid,
      input  wr_height,
      input  wr_side,
      output wr_ready
   );

endinterface

// File: rtl/wall_row_shader_span_buffer.sv
// row_span_buffer: one pending slot filled by the tracer, one active slot
// used by the shading mux. The pending span moves to active on the last
// clock before each visible line; an empty pending slot at that moment
// keeps the old span and raises a one-clock underrun pulse.
module row_span_buffer
   import wall_row_shader_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [POS_W-1:0] vpos,
   input  logic             hmax,
   input  logic             vmax,
   wall_row_shader_if.slave wr,
   output span_t            active_o,
   output logic             underrun_o
);

   logic  pend_full_q, pend_full_d;
   span_t pend_q,      pend_d;
   span_t active_q,    active_d;
   logic  underrun_q,  underrun_d;
   logic  swap;
   logic  accept;

   // Ready depends only on the registered slot state
   assign wr.wr_ready = ~pend_full_q;
   assign active_o    = active_q;
   assign underrun_o  = underrun_q;

   // Next-state: swap into active first, then a new accept refills pending
   always_comb begin
      swap        = hmax && (vmax || (vpos < LAST_VIS_LINE));
      accept      = wr.wr_valid && !pend_full_q;
      pend_full_d = pend_full_q;
      pend_d      = pend_q;
      active_d    = active_q;
      underrun_d  = swap && !pend_full_q;
      if (swap && pend_full_q) begin
         active_d    = pend_q;
         pend_full_d = 1'b0;
      end
      if (accept) begin
         pend_d      = height_to_span(wr.wr_height, wr.wr_side);
         pend_full_d = 1'b1;
      end
   end

   // Slot registers; reset drops any pending span and restores the empty wall
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_full_q <= 1'b0;
         pend_q      <= NO_WALL;
         active_q    <= NO_WALL;
         underrun_q  <= 1'b0;
      end else begin
         pend_full_q <= pend_full_d;
         pend_q      <= pend_d;
         active_q    <= active_d;
         underrun_q  <= underrun_d;
      end
   end

endmodule

// File: rtl/wall_row_shader.sv
// Pixel stage after the VGA timing generator: paints sky | wall | floor
// for each line from the double-buffered wall span and re-registers the
// syncs so colour and sync leave on the same clock.
module wall_row_shader
   import wall_row_shader_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [POS_W-1:0] hpos,
   input  logic [POS_W-1:0] vpos,
   input  logic             hmax,
   input  logic             vmax,
   input  logic             visible,
   input  logic             hsync_in,
   input  logic             vsync_in,
   wall_row_shader_if.slave wr,
   output logic [RGB_W-1:0] rgb,
   output logic             hsync,
   output logic             vsync,
   output logic             underrun
);

   span_t            active;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic             hsync_q, vsync_q;

   row_span_buffer u_span (
      .clk        (clk),
      .reset      (reset),
      .vpos       (vpos),
      .hmax       (hmax),
      .vmax       (vmax),
      .wr         (wr),
      .active_o   (active),
      .underrun_o (underrun)
   );

   // Shading mux: blank outside the view, else pick region by column
   always_comb begin
      rgb_d = BLANK_RGB;
      if (visible) begin
         if (hpos < active.start) begin
            rgb_d = SKY_RGB;
         end else if (hpos < active.stop) begin
            rgb_d = (active.side == SIDE_1) ? WALL1_RGB : WALL0_RGB;
         end else begin
            rgb_d = FLOOR_RGB;
         end
      end
   end

   // Colour and syncs share one register stage to keep them aligned
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_q   <= BLANK_RGB;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= hsync_in;
         vsync_q <= vsync_in;
      end
   end

   assign rgb   = rgb_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;

endmodule

// File: tb/tb_wall_row_shader.sv
// Bench for wall_row_shader: a shortened timing generator (a subset of the
// frame's lines, full-width lines) drives the DUT while a line-level model
// of the height handoff predicts every output on every clock.
module tb_wall_row_shader;
   import wall_row_shader_pkg::*;

   localparam int H_TOT  = 656;
   localparam int N_LINE = 13;
   localparam int BOUND  = 20000;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] hpos, vpos;
   logic       hmax, vmax, visible, hsync_in, vsync_in;
   logic [5:0] rgb;
   logic       hsync, vsync, underrun;

   wall_row_shader_if wr_if ();

   wall_row_shader dut (
      .clk      (clk),
      .reset    (reset),
      .hpos     (hpos),
      .vpos     (vpos),
      .hmax     (hmax),
      .vmax     (vmax),
      .visible  (visible),
      .hsync_in (hsync_in),
      .vsync_in (vsync_in),
      .wr       (wr_if.slave),
      .rgb      (rgb),
      .hsync    (hsync),
      .vsync    (vsync),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   // Lines visited per frame: first visible lines, last visible lines, blanking
   int vseq [N_LINE] = '{0, 1, 2, 3, 4, 5, 6, 7, 477, 478, 479, 480, 524};
   int vi, hc;       // timing generator position
   int s_v, s_h;     // pixel whose colour is on rgb at the current check

   typedef struct {int h; bit s;} item_t;
   item_t tq[$];     // tracer's outstanding offers, head is on the bus

   // Reference model state (line-level view of the handoff)
   bit       m_pend;
   int       m_pend_h, m_act_h;
   bit       m_pend_s, m_act_s;
   bit       m_acc;
   logic [5:0] e_rgb;
   logic     e_hs, e_vs, e_und, e_ready;

   int  n_tests = 0;
   int  n_fail  = 0;
   bit  rand_en = 0;
   bit  spot_en = 0;
   bit  cnt_en  = 0;
   int  und_cnt = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s line=%0d px=%0d got=%0h want=%0h", tag, s_v, s_h, obs, exp);
      end
   endtask

   // Wall covers columns whose offset from centre lies in [-half, half)
   function automatic logic [5:0] ref_colour(bit vis, int c, int hgt, bit side);
      int half;
      half = hgt / 2;
      if (!vis) return 6'd0;
      if (c - 320 < -half) return SKY_RGB;
      if (c - 320 < half) return side ? WALL1_RGB : WALL0_RGB;
      return FLOOR_RGB;
   endfunction

   task automatic apply_timing();
      int v;
      v        = vseq[vi];
      hpos     = 10'(hc);
      vpos     = 10'(v);
      hmax     = (hc == H_TOT - 1);
      vmax     = (v == 524);
      visible  = (hc < 640) && (v < 480);
      hsync_in = (hc >= 648) && (hc < 652);
      vsync_in = (v == 480);
   endtask

   task automatic drive_tr();
      if (tq.size() > 0) begin
         wr_if.wr_valid  = 1'b1;
         wr_if.wr_height = 10'(tq[0].h);
         wr_if.wr_side   = tq[0].s;
      end else begin
         wr_if.wr_valid = 1'b0;
      end
   endtask

   // Model: a new line's span is the one last handed over before the line starts
   task automatic model_update();
      bit swap, acc;
      m_acc = 0;
      if (reset) begin
         m_pend  = 0;
         m_act_h = 0;
         m_act_s = 0;
         e_rgb   = 6'd0;
         e_hs    = 0;
         e_vs    = 0;
         e_und   = 0;
      end else begin
         e_rgb = ref_colour(visible, int'(hpos), m_act_h, m_act_s);
         e_hs  = hsync_in;
         e_vs  = vsync_in;
         swap  = hmax && (vmax || int'(vpos) < V_VIEW - 1);
         e_und = swap && !m_pend;
         acc   = wr_if.wr_valid && !m_pend;
         if (swap && m_pend) begin
            m_act_h = m_pend_h;
            m_act_s = m_pend_s;
            m_pend  = 0;
         end
         if (acc) begin
            m_pend_h = int'(wr_if.wr_height);
            m_pend_s = wr_if.wr_side;
            m_pend   = 1;
            $display("[TB] accept height=%0d side=%0d at line=%0d px=%0d",
                     m_pend_h, m_pend_s, vseq[vi], hc);
         end
         m_acc = acc;
      end
      e_ready = !m_pend;
   endtask

   task automatic push_random();
      item_t it;
      int    edges [6] = '{0, 1, 639, 640, 641, 1023};
      it.h = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 5)]
                                         : int'($urandom_range(0, 1023));
      it.s = 1'($urandom_range(0, 1));
      tq.push_back(it);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      s_v = vseq[vi];
      s_h = hc;
      #1;
      if (m_acc) void'(tq.pop_front());
      hc++;
      if (hc == H_TOT) begin
         hc = 0;
         vi = (vi + 1) % N_LINE;
      end
      apply_timing();
      if (rand_en && tq.size() == 0 && $urandom_range(0, 299) == 0) begin
         push_random();
         if ($urandom_range(0, 3) == 0) push_random();
      end
      drive_tr();
      @(negedge clk);
      check("rgb", 16'(rgb), 16'(e_rgb));
      check("hsync", 16'(hsync), 16'(e_hs));
      check("vsync", 16'(vsync), 16'(e_vs));
      check("underrun", 16'(underrun), 16'(e_und));
      check("wr_ready", 16'(wr_if.wr_ready), 16'(e_ready));
      if (cnt_en && underrun === 1'b1) und_cnt++;
      if (spot_en) begin
         if (s_v == 5 && s_h == 219) check("l5_c219_sky", 16'(rgb), 16'(SKY_RGB));
         if (s_v == 5 && s_h == 220) check("l5_c220_wall", 16'(rgb), 16'(WALL0_RGB));
         if (s_v == 5 && s_h == 419) check("l5_c419_wall", 16'(rgb), 16'(WALL0_RGB));
         if (s_v == 5 && s_h == 420) check("l5_c420_floor", 16'(rgb), 16'(FLOOR_RGB));
         if (s_v == 6 && (s_h == 0 || s_h == 639))
            check("l6_full_wall1", 16'(rgb), 16'(WALL1_RGB));
      end
   endtask

   task automatic wait_until(input int v, input int h);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(vseq[vi] == v && hc == h) && n < BOUND);
      check("wait_timeout", 16'(n < BOUND), 16'd1);
   endtask

   task automatic push(input int h, input bit s);
      item_t it;
      it.h = h;
      it.s = s;
      tq.push_back(it);
      drive_tr();
   endtask

   initial begin
      reset           = 1'b1;
      vi              = N_LINE - 1;
      hc              = 600;
      wr_if.wr_valid  = 1'b0;
      wr_if.wr_height = '0;
      wr_if.wr_side   = 1'b0;
      apply_timing();
      repeat (3) step();
      reset = 1'b0;

      // Idle frame: no writes, an underrun on every swap
      wait_until(0, 0);
      und_cnt = 0;
      cnt_en  = 1;
      wait_until(0, 0);
      cnt_en  = 0;
      check("idle_underruns", 16'(und_cnt), 16'd11);

      // Directed spans on lines 5 and 6, then a held second offer
      spot_en = 1;
      wait_until(4, 10);
      push(200, 0);
      wait_until(5, 650);
      push(1023, 1);
      wait_until(7, 100);
      push(300, 0);
      push(50, 1);
      wait_until(7, 200);
      check("hold_not_ready", 16'(wr_if.wr_ready), 16'd0);
      check("hold_valid_kept", 16'(wr_if.wr_valid), 16'd1);
      wait_until(0, 0);
      spot_en = 0;

      // Offer exactly on the swap clock with pending empty
      wait_until(2, 655);
      push(400, 1);
      step();
      check("swap_accept_underrun", 16'(underrun), 16'd1);
      check("swap_accept_not_ready", 16'(wr_if.wr_ready), 16'd0);

      // Reset mid-line while pending holds a span
      wait_until(5, 290);
      push(600, 0);
      wait_until(5, 300);
      check("pend_full_before_reset", 16'(wr_if.wr_ready), 16'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("reset_rgb", 16'(rgb), 16'd0);
      check("reset_ready", 16'(wr_if.wr_ready), 16'd1);
      wait_until(0, 0);

      // Random offers over several frames
      rand_en = 1;
      repeat (3) wait_until(0, 0);
      rand_en = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
